// File: rtl/lp_dma_burst.sv
// Bus-read prefetch engine: fetches words on request/ack into a small FIFO drained by the consumer.
// Define LP_DMA_TEST_EN to enable the ack-suppression and forced-parity test hooks.
module lp_dma_burst #(
    parameter int DATA_WIDTH = 36,
    parameter int FIFO_DEPTH = 4,
    parameter int TMO_WIDTH  = 9,
    parameter int TMO_VAL    = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          devREQO,
    input  logic                          devACKI,
    input  logic [DATA_WIDTH-1:0]         devDATAI,
    input  logic                          lpDONE,
    input  logic                          lpERR,
    input  logic                          lpCMDGO,
    input  logic                          lpCMDSTOP,
    input  logic                          lpTESTMSYN,
    input  logic                          lpTESTMPE,
    input  logic                          popREQ,
    output logic [DATA_WIDTH-1:0]         popDATA,
    output logic                          popVALID,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCOUNT,
    output logic                          lpGO,
    output logic                          lpINCR,
    output logic                          lpSETMSYN,
    output logic                          lpSETMPE
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT, S_FETCH, S_READ, S_NEXT, S_CHECK, S_DRAIN, S_ACKFAIL, S_DONE
    } state_t;

    state_t                 r_state, w_next;
    logic                   r_req, r_go, r_incr, r_msyn;
    logic                   w_req_nxt, w_go_nxt, w_incr_nxt, w_msyn_nxt;
    logic [TMO_WIDTH-1:0]   r_timer, w_timer_nxt;
    logic                   w_push, w_pop, w_flush, w_ack, w_tst_msyn;

    logic [DATA_WIDTH-1:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wptr, r_rptr;
    logic [CW-1:0]          r_count;

`ifdef LP_DMA_TEST_EN
    assign w_tst_msyn = lpTESTMSYN;
    assign lpSETMPE   = (r_state == S_READ) & lpTESTMPE;
`else
    logic w_unused_tst;
    assign w_unused_tst = lpTESTMSYN ^ lpTESTMPE;
    assign w_tst_msyn   = 1'b0;
    assign lpSETMPE     = 1'b0;
`endif

    assign w_ack = devACKI & ~w_tst_msyn;

    always_comb begin
        w_next      = r_state;
        w_req_nxt   = r_req;
        w_go_nxt    = r_go;
        w_incr_nxt  = 1'b0;
        w_msyn_nxt  = 1'b0;
        w_timer_nxt = r_timer;
        w_push      = 1'b0;
        w_flush     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (lpCMDGO && !lpERR) begin
                    w_go_nxt = 1'b1;
                    w_flush  = 1'b1;
                    w_next   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!lpCMDGO) w_next = S_FETCH;
            end
            S_FETCH: begin
                if (r_count < CW'(FIFO_DEPTH)) begin
                    w_req_nxt   = 1'b1;
                    w_timer_nxt = TMO_WIDTH'(TMO_VAL);
                    w_next      = S_READ;
                end
            end
            S_READ: begin
                if (w_ack) begin
                    w_push     = 1'b1;
                    w_incr_nxt = 1'b1;
                    w_req_nxt  = 1'b0;
                    w_next     = S_NEXT;
                end else if (r_timer == '0) begin
                    w_req_nxt = 1'b0;
                    w_next    = S_ACKFAIL;
                end else begin
                    w_timer_nxt = r_timer - TMO_WIDTH'(1);
                end
            end
            S_NEXT:  w_next = S_CHECK;
            S_CHECK: w_next = lpDONE ? S_DRAIN : S_FETCH;
            S_DRAIN: begin
                if (r_count == '0) w_next = S_DONE;
            end
            S_ACKFAIL: begin
                w_msyn_nxt = 1'b1;
                w_next     = S_DONE;
            end
            S_DONE: begin
                w_go_nxt = 1'b0;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // Stop wins over everything, including a push landing the same cycle.
        if (lpCMDSTOP) begin
            w_next     = S_IDLE;
            w_go_nxt   = 1'b0;
            w_req_nxt  = 1'b0;
            w_incr_nxt = 1'b0;
            w_msyn_nxt = 1'b0;
            w_push     = 1'b0;
            w_flush    = 1'b1;
        end
    end

    assign w_pop = popREQ & (r_count != '0) & ~w_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_go    <= 1'b0;
            r_incr  <= 1'b0;
            r_msyn  <= 1'b0;
            r_timer <= TMO_WIDTH'(TMO_VAL);
        end else begin
            r_state <= w_next;
            r_req   <= w_req_nxt;
            r_go    <= w_go_nxt;
            r_incr  <= w_incr_nxt;
            r_msyn  <= w_msyn_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= devDATAI;
    end

    assign devREQO   = r_req;
    assign lpGO      = r_go;
    assign lpINCR    = r_incr;
    assign lpSETMSYN = r_msyn;
    assign popDATA   = r_mem[r_rptr];
    assign popVALID  = (r_count != '0);
    assign fifoCOUNT = r_count;

endmodule

// File: tb/tb_lp_dma_burst.sv
// Directed bench for lp_dma_burst: per-cycle vector table plus hand-written burst,
// back-pressure, timeout, stop, reset and test-hook sequences.
module tb_lp_dma_burst;

    localparam logic [35:0] WBASE = 36'hA_5A5A_0000;
    localparam logic [35:0] D1 = 36'h1_2345_6789;
    localparam logic [35:0] D2 = 36'h8_7654_3210;
    localparam logic [35:0] D3 = 36'hF_0F0F_0F0F;

    logic        clk = 1'b0;
    logic        rst;
    logic        devREQO, devACKI;
    logic [35:0] devDATAI, popDATA;
    logic        lpDONE, lpERR, lpCMDGO, lpCMDSTOP, lpTESTMSYN, lpTESTMPE, popREQ;
    logic        popVALID, lpGO, lpINCR, lpSETMSYN, lpSETMPE;
    logic [2:0]  fifoCOUNT;

    logic        m_ack, m_done;
    logic [35:0] m_data;
    logic        resp_en, auto_done, cnt_clr;
    logic        a_ack = 1'b0;
    logic [35:0] a_data = '0;
    int          age = 0, widx = 0;
    int          incr_cnt = 0, req_rises = 0, job_len;
    logic        prev_req = 1'b0;

    int tests = 0, fails = 0;

    assign devACKI  = resp_en ? a_ack  : m_ack;
    assign devDATAI = resp_en ? a_data : m_data;
    assign lpDONE   = m_done | (auto_done && incr_cnt >= job_len);

    lp_dma_burst dut (
        .clk(clk), .rst(rst),
        .devREQO(devREQO), .devACKI(devACKI), .devDATAI(devDATAI),
        .lpDONE(lpDONE), .lpERR(lpERR), .lpCMDGO(lpCMDGO), .lpCMDSTOP(lpCMDSTOP),
        .lpTESTMSYN(lpTESTMSYN), .lpTESTMPE(lpTESTMPE),
        .popREQ(popREQ), .popDATA(popDATA), .popVALID(popVALID),
        .fifoCOUNT(fifoCOUNT), .lpGO(lpGO), .lpINCR(lpINCR),
        .lpSETMSYN(lpSETMSYN), .lpSETMPE(lpSETMPE)
    );

    always #5 clk = ~clk;

    // Bus slave: acks two clocks after a request rises, data WBASE+n in order.
    always @(negedge clk) begin
        if (cnt_clr || !resp_en) begin
            a_ack = 1'b0;
            age   = 0;
            if (cnt_clr) widx = 0;
        end else if (a_ack) begin
            a_ack = 1'b0;
            age   = 0;
        end else if (devREQO) begin
            if (age >= 1) begin
                a_ack  = 1'b1;
                a_data = WBASE + 36'(widx);
                widx++;
                age    = 0;
            end else begin
                age++;
            end
        end
    end

    always @(negedge clk) begin
        if (cnt_clr) begin
            incr_cnt  = 0;
            req_rises = 0;
            prev_req  = 1'b0;
        end else begin
            if (lpINCR) incr_cnt++;
            if (devREQO && !prev_req) req_rises++;
            prev_req = devREQO;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic go, stop, err, ack, pop, done;
        logic [35:0] data;
        logic e_req, e_go, e_incr, e_pv;
        logic [2:0] e_cnt;
        logic [35:0] e_pd;
    } vec_t;
    vec_t tv[$];

    task automatic add(input logic go, stop, err, ack, pop, done, input logic [35:0] data,
                       input logic e_req, e_go, e_incr, input logic [2:0] e_cnt,
                       input logic e_pv, input logic [35:0] e_pd);
        vec_t v;
        v.go = go; v.stop = stop; v.err = err; v.ack = ack; v.pop = pop; v.done = done;
        v.data = data; v.e_req = e_req; v.e_go = e_go; v.e_incr = e_incr;
        v.e_cnt = e_cnt; v.e_pv = e_pv; v.e_pd = e_pd;
        tv.push_back(v);
    endtask

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cnt_clr = 1'b1; resp_en = 1'b0; auto_done = 1'b0; job_len = 0;
        m_ack = 1'b0; m_data = '0; m_done = 1'b0;
        lpERR = 1'b0; lpCMDGO = 1'b0; lpCMDSTOP = 1'b0;
        lpTESTMSYN = 1'b0; lpTESTMPE = 1'b0; popREQ = 1'b0;
        tick(); tick();
        rst = 1'b0; cnt_clr = 1'b0;
    endtask

    // Leaves the engine in FETCH.
    task automatic go_pulse();
        lpCMDGO = 1'b1; tick();
        lpCMDGO = 1'b0; tick();
    endtask

    task automatic man_ack(input logic [35:0] d);
        m_ack = 1'b1; m_data = d; tick();
        m_ack = 1'b0; tick(); tick(); tick();
    endtask

    initial begin
        int hi;
        logic seen, mpe_any;

        //    go st er ak pp dn data | req go inc cnt pv pd
        add(1, 0, 1, 0, 0, 0, '0,   0, 0, 0, 3'd0, 0, '0);
        add(1, 0, 0, 0, 0, 0, '0,   0, 1, 0, 3'd0, 0, '0);
        add(1, 0, 0, 0, 0, 0, '0,   0, 1, 0, 3'd0, 0, '0);
        add(0, 0, 0, 0, 0, 0, '0,   0, 1, 0, 3'd0, 0, '0);
        add(0, 0, 0, 0, 0, 0, '0,   1, 1, 0, 3'd0, 0, '0);
        add(0, 0, 0, 0, 0, 0, '0,   1, 1, 0, 3'd0, 0, '0);
        add(0, 0, 0, 1, 0, 0, D1,   0, 1, 1, 3'd1, 1, D1);
        add(0, 0, 0, 0, 0, 0, '0,   0, 1, 0, 3'd1, 1, D1);
        add(0, 0, 0, 0, 0, 0, '0,   0, 1, 0, 3'd1, 1, D1);
        add(0, 0, 0, 0, 0, 0, '0,   1, 1, 0, 3'd1, 1, D1);
        add(0, 0, 0, 1, 1, 0, D2,   0, 1, 1, 3'd1, 1, D2);
        add(0, 0, 0, 0, 1, 0, '0,   0, 1, 0, 3'd0, 0, '0);
        add(0, 0, 0, 0, 1, 0, '0,   0, 1, 0, 3'd0, 0, '0);
        add(0, 0, 0, 0, 0, 0, '0,   1, 1, 0, 3'd0, 0, '0);
        add(0, 0, 0, 1, 0, 0, D3,   0, 1, 1, 3'd1, 1, D3);
        add(0, 0, 0, 0, 0, 0, '0,   0, 1, 0, 3'd1, 1, D3);
        add(0, 0, 0, 0, 0, 1, '0,   0, 1, 0, 3'd1, 1, D3);
        add(0, 0, 0, 0, 0, 1, '0,   0, 1, 0, 3'd1, 1, D3);
        add(0, 0, 0, 0, 1, 1, '0,   0, 1, 0, 3'd0, 0, '0);
        add(0, 0, 0, 0, 0, 0, '0,   0, 1, 0, 3'd0, 0, '0);
        add(0, 0, 0, 0, 0, 0, '0,   0, 0, 0, 3'd0, 0, '0);
        add(1, 0, 0, 0, 0, 0, '0,   0, 1, 0, 3'd0, 0, '0);
        add(1, 1, 0, 0, 0, 0, '0,   0, 0, 0, 3'd0, 0, '0);

        do_reset();
        check("rst_req", devREQO, 0);
        check("rst_go", lpGO, 0);
        check("rst_incr", lpINCR, 0);
        check("rst_cnt", fifoCOUNT, 0);
        check("rst_pv", popVALID, 0);
        check("rst_msyn", lpSETMSYN, 0);

        for (int i = 0; i < tv.size(); i++) begin
            lpCMDGO = tv[i].go; lpCMDSTOP = tv[i].stop; lpERR = tv[i].err;
            m_ack = tv[i].ack; popREQ = tv[i].pop; m_done = tv[i].done; m_data = tv[i].data;
            tick();
            check($sformatf("vec%0d_req", i), devREQO, tv[i].e_req);
            check($sformatf("vec%0d_go", i), lpGO, tv[i].e_go);
            check($sformatf("vec%0d_incr", i), lpINCR, tv[i].e_incr);
            check($sformatf("vec%0d_cnt", i), fifoCOUNT, tv[i].e_cnt);
            check($sformatf("vec%0d_pv", i), popVALID, tv[i].e_pv);
            if (tv[i].e_pv) check($sformatf("vec%0d_pd", i), popDATA, tv[i].e_pd);
        end

        // Three-word burst, no pops: must park in DRAIN, then drain in order.
        do_reset();
        resp_en = 1'b1; auto_done = 1'b1; job_len = 3;
        go_pulse();
        for (int i = 0; i < 200 && incr_cnt < 3; i++) tick();
        repeat (6) tick();
        check("burst_incr", incr_cnt, 3);
        check("burst_reqs", req_rises, 3);
        check("burst_cnt", fifoCOUNT, 3);
        check("burst_go", lpGO, 1);
        check("burst_req_idle", devREQO, 0);
        popREQ = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("drain_pv%0d", k), popVALID, 1);
            check($sformatf("drain_pd%0d", k), popDATA, WBASE + 36'(k));
            tick();
        end
        popREQ = 1'b0;
        check("drain_pv_end", popVALID, 0);
        check("drain_go_0", lpGO, 1);
        tick();
        check("drain_go_1", lpGO, 1);
        tick();
        check("drain_go_2", lpGO, 0);

        // Six-word job into a four-deep FIFO: requests stop when full, one pop frees one.
        do_reset();
        resp_en = 1'b1; auto_done = 1'b1; job_len = 6;
        go_pulse();
        for (int i = 0; i < 200 && fifoCOUNT != 3'd4; i++) tick();
        repeat (20) tick();
        check("full_reqs", req_rises, 4);
        check("full_req_low", devREQO, 0);
        check("full_cnt", fifoCOUNT, 4);
        check("full_incr", incr_cnt, 4);
        check("full_head", popDATA, WBASE);
        popREQ = 1'b1; tick(); popREQ = 1'b0;
        repeat (20) tick();
        check("refill_reqs", req_rises, 5);
        check("refill_cnt", fifoCOUNT, 4);
        check("refill_incr", incr_cnt, 5);
        check("refill_head", popDATA, WBASE + 36'd1);
        lpCMDSTOP = 1'b1; tick(); lpCMDSTOP = 1'b0;

        // No ack: request held through the full timeout, then a single error pulse.
        do_reset();
        go_pulse();
        hi = 0; seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (devREQO) hi++;
            if (lpSETMSYN) begin seen = 1'b1; break; end
        end
        check("tmo_seen", seen, 1);
        check("tmo_req_cycles", hi, 256);
        check("tmo_req_low", devREQO, 0);
        tick();
        check("tmo_pulse_w", lpSETMSYN, 0);
        check("tmo_go", lpGO, 0);

        // Stop while a request is outstanding with two words buffered.
        do_reset();
        go_pulse(); tick();
        man_ack(D1);
        man_ack(D2);
        check("stop_pre_req", devREQO, 1);
        check("stop_pre_cnt", fifoCOUNT, 2);
        lpCMDSTOP = 1'b1; tick(); lpCMDSTOP = 1'b0;
        check("stop_req", devREQO, 0);
        check("stop_go", lpGO, 0);
        check("stop_cnt", fifoCOUNT, 0);
        check("stop_pv", popVALID, 0);
        tick();
        check("stop_idle_req", devREQO, 0);

        // Reset mid-request, then a stray ack must be ignored.
        go_pulse(); tick();
        check("rrst_pre_req", devREQO, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rrst_req", devREQO, 0);
        check("rrst_go", lpGO, 0);
        m_ack = 1'b1; m_data = D3; tick();
        check("rrst_incr", lpINCR, 0);
        tick(); m_ack = 1'b0;
        check("rrst_cnt", fifoCOUNT, 0);
        check("rrst_pv", popVALID, 0);

        // Test hooks with a live ack.
        do_reset();
        lpTESTMSYN = 1'b1; lpTESTMPE = 1'b1; m_ack = 1'b1; m_data = D2;
        go_pulse(); tick();
`ifdef LP_DMA_TEST_EN
        check("tst_mpe", lpSETMPE, 1);
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (lpSETMSYN) begin seen = 1'b1; break; end
        end
        check("tst_msyn_seen", seen, 1);
        check("tst_cnt", fifoCOUNT, 0);
`else
        mpe_any = lpSETMPE;
        tick();
        mpe_any |= lpSETMPE;
        check("tst_incr", lpINCR, 1);
        check("tst_cnt", fifoCOUNT, 1);
        check("tst_pd", popDATA, D2);
        m_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            mpe_any |= lpSETMPE;
        end
        check("tst_mpe_never", mpe_any, 0);
`endif
        lpTESTMSYN = 1'b0; lpTESTMPE = 1'b0; m_ack = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
